// File: rtl/input_pattern.sv
// Player-input checker for the LED memory game: synchronizes and debounces the
// push buttons, then scores each press against the pattern latched at start.
module input_pattern #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] level,
  input  logic [2:0] pattern_1,
  input  logic [2:0] pattern_2,
  input  logic [2:0] pattern_3,
  input  logic [2:0] pattern_4,
  input  logic [2:0] pattern_5,
  input  logic [2:0] pattern_6,
  input  logic [2:0] pattern_7,
  input  logic [2:0] pattern_8,
  input  logic [2:0] pattern_9,
  input  logic [2:0] pattern_10,
  input  logic [2:0] pattern_11,
  input  logic [2:0] pattern_12,
  input  logic [2:0] pattern_13,
  input  logic [2:0] pattern_14,
  input  logic [2:0] pattern_15,
  input  logic [2:0] pattern_16,
  input  logic       button_1,
  input  logic       button_2,
  input  logic       button_3,
  input  logic       button_4,
  input  logic       button_5,
  input  logic       button_6,
  input  logic       button_7,
  input  logic       button_8,
  output logic       led_1,
  output logic       led_2,
  output logic       led_3,
  output logic       led_4,
  output logic       led_5,
  output logic       led_6,
  output logic       led_7,
  output logic       led_8,
  output logic [4:0] step_count,
  output logic       success,
  output logic       fail,
  output logic       input_pattern_end
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_PRESS, S_WAIT_RELEASE, S_DONE} state_t;

  logic [7:0]    btn_raw;
  logic [7:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DW-1:0] deb_cnt_q;

  state_t        state_q, state_d;
  logic [7:0]    led_q, led_d;
  logic [4:0]    step_q, step_d;
  logic          success_q, success_d;
  logic          fail_q, fail_d;
  logic          end_q, end_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [2:0]    level_q;
  logic [2:0]    pat_q [16];
  logic [4:0]    seq_len;
  logic [7:0]    expected_onehot;
  logic          press_evt;
  logic          start;

  assign btn_raw = {button_8, button_7, button_6, button_5,
                    button_4, button_3, button_2, button_1};

  // Counter reloads on the same edge the synced vector changes, so an accepted
  // value has been stable for DEBOUNCE_CYCLES edges after the change.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync1_q != sync2_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end
  end

  assign start = (state_q == S_IDLE) && enable;

  always_ff @(posedge clk_1) begin
    if (start) begin
      level_q    <= level;
      pat_q[0]   <= pattern_1;
      pat_q[1]   <= pattern_2;
      pat_q[2]   <= pattern_3;
      pat_q[3]   <= pattern_4;
      pat_q[4]   <= pattern_5;
      pat_q[5]   <= pattern_6;
      pat_q[6]   <= pattern_7;
      pat_q[7]   <= pattern_8;
      pat_q[8]   <= pattern_9;
      pat_q[9]   <= pattern_10;
      pat_q[10]  <= pattern_11;
      pat_q[11]  <= pattern_12;
      pat_q[12]  <= pattern_13;
      pat_q[13]  <= pattern_14;
      pat_q[14]  <= pattern_15;
      pat_q[15]  <= pattern_16;
    end
  end

  // Levels 6 and 7 both cap at the 16-entry pattern store.
  assign seq_len         = (level_q >= 3'd6) ? 5'd16 : 5'd4 + {1'b0, level_q, 1'b0};
  assign expected_onehot = 8'd1 << pat_q[step_q[3:0]];
  assign press_evt       = (deb_q != 8'd0) && (deb_prev_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    step_d    = step_q;
    success_d = success_q;
    fail_d    = fail_q;
    end_d     = 1'b0;
    timer_d   = timer_q;
    if (state_q != S_IDLE && !enable) begin
      state_d   = S_IDLE;
      led_d     = '0;
      step_d    = '0;
      success_d = 1'b0;
      fail_d    = 1'b0;
      timer_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_WAIT_PRESS;
            step_d  = '0;
            timer_d = '0;
          end
        end
        S_WAIT_PRESS: begin
          // A one-hot match also rejects multi-button presses.
          if (press_evt) begin
            if (deb_q == expected_onehot) begin
              led_d   = deb_q;
              step_d  = step_q + 5'd1;
              state_d = S_WAIT_RELEASE;
            end else begin
              fail_d  = 1'b1;
              end_d   = 1'b1;
              state_d = S_DONE;
            end
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            fail_d  = 1'b1;
            end_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WAIT_RELEASE: begin
          if (deb_q == 8'd0) begin
            led_d = '0;
            if (step_q == seq_len) begin
              success_d = 1'b1;
              end_d     = 1'b1;
              state_d   = S_DONE;
            end else begin
              timer_d = '0;
              state_d = S_WAIT_PRESS;
            end
          end
        end
        S_DONE: begin
          led_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q   <= S_IDLE;
      led_q     <= '0;
      step_q    <= '0;
      success_q <= 1'b0;
      fail_q    <= 1'b0;
      end_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      step_q    <= step_d;
      success_q <= success_d;
      fail_q    <= fail_d;
      end_q     <= end_d;
      timer_q   <= timer_d;
    end
  end

  assign {led_8, led_7, led_6, led_5, led_4, led_3, led_2, led_1} = led_q;
  assign step_count        = step_q;
  assign success           = success_q;
  assign fail              = fail_q;
  assign input_pattern_end = end_q;

endmodule

// File: doc/input_pattern.md
Name: input_pattern

Overview:
- Player-input checker for the LED memory game.
- After the display block finishes showing a pattern, this block reads the 8 push buttons, debounces them, and compares each press against the stored pattern sequence.
- It reports success or failure to the game controller.
- It is the reader end of the pattern bus that the display block drives out to the LEDs.

Parameters:
DEBOUNCE_CYCLES, 200, clk_1 cycles the synchronized button vector must stay unchanged before it is accepted (20 ms at 10 kHz).
TIMEOUT_CYCLES, 50000, max clk_1 cycles allowed in WAIT_PRESS before fail (5 s).

Ports:
clk_1  input  1  system clock, 10 kHz; the only clock.
rst  input  1  synchronous reset, active-high.
enable  input  1  start/hold input phase; level-sensitive.
level  input  3  game level; sets sequence length.
pattern_1..pattern_16  input  3 each  expected LED codes (0..7), in order.
button_1..button_8  input  1 each  raw asynchronous push buttons, active-high.
led_1..led_8  output  1 each  echo of the currently accepted press.
step_count  output  5  number of correct presses so far (0..16).
success  output  1  held high in DONE when the full sequence matched.
fail  output  1  held high in DONE on mismatch, multi-press or timeout.
input_pattern_end  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Clock and reset: all logic on posedge clk_1. rst is synchronous and active-high.
- Reset clears:
  - state = IDLE;
  - all LEDs, success, fail, input_pattern_end = 0; step_count = 0;
  - sync flops, debounced vector, debounce counter and timeout counter = 0.
- Sequence length: N = min(4 + 2*level, 16). level 0→4, 2→8, 6 and 7→16.
- Code mapping: pattern value p corresponds to button_(p+1) and led_(p+1).
- Input path:
  - 2-FF synchronizer on the 8-bit button vector.
  - One shared stability counter: it reloads to 0 whenever the synced vector differs from the previous cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the vector unchanged, the debounced vector loads the synced vector.
  - The debounce path runs in every state.
- Press event: the debounced vector goes from all-zero to non-zero while in WAIT_PRESS.
  - Buttons already held on entry to WAIT_PRESS do not count until they are released.
- States:
  - IDLE:
    - Outputs 0.
    - On enable=1: latch level and pattern_1..16 into internal registers, set step_count=0, clear timer, go to WAIT_PRESS.
    - Later changes to the pattern and level inputs are ignored until the next start.
  - WAIT_PRESS:
    - Timer increments each cycle. At TIMEOUT_CYCLES-1 go to DONE with fail=1.
    - On a press event, decide the cycle after the debounced vector updates:
      - Exactly one bit set and its index equals the latched pattern[step_count]: light that LED, step_count+1, go to WAIT_RELEASE.
      - Wrong index, or more than one bit set: go to DONE with fail=1. No LED is lit.
    - If timeout and press event occur in the same cycle, the press wins.
  - WAIT_RELEASE:
    - Echo LED held; no timeout.
    - When the debounced vector is all-zero: clear LEDs.
    - Then go to DONE with success=1 if step_count==N, else go to WAIT_PRESS with timer cleared.
  - DONE:
    - input_pattern_end = 1 for the entry cycle only.
    - success/fail held, exactly one of them high.
    - LEDs 0.
    - Stays in DONE until enable=0, then goes to IDLE with success/fail cleared.
- enable=0 in any non-IDLE state:
  - Next cycle goes to IDLE and all outputs clear.
  - No end pulse, no success/fail.
- rst mid-operation: same as the reset values above, next cycle; no end pulse.
- Latency from a raw button edge to the LED echo: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Test Plan:
Bench settings for all scenarios: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, rst pulsed high for 2 cycles.
1. level=0, pattern_1..4 = 3,0,7,5, enable=1; press/release button_4, 1, 8, 6 (10 cycles each) -> led_4 echoes 2+4+1 cycles after the button_4 edge; step_count steps 1..4; success=1; input_pattern_end is a single pulse after the last release; fail=0.
2. level=2 (N=8), patterns 0..7; press correct for steps 1-3, then button_1 when pattern_4=3 -> fail=1, step_count=3, end pulse, no LED lit.
3. Press button_2 and button_3 simultaneously at step 1 -> fail=1, step_count=0. A 2-cycle glitch on button_5 before the press -> ignored by the debounce.
4. enable=1, no presses for 100 cycles -> fail=1 exactly at timeout. Second check: a press landing on the timeout cycle is evaluated and timeout is not taken.
5. Button held at enable rise -> no step until it is released and pressed again. pattern_1 changed after start -> the latched value is still used.
6. Mid-sequence rst=1 or enable=0 -> IDLE next cycle; all outputs 0; no end pulse. Re-enable restarts at step_count=0.
